clock_divider_bank: RTL
=======================

Name: clock_divider_bank

Overview:
- Multi-channel programmable clock divider; successor to the fixed power-of-two divider.
- Each of CHANNELS independent channels produces:
  - a square-wave slow clock with runtime-programmable half-period;
  - a one-cycle tick strobe on each rising edge of that slow clock.
- Divisors are written through a simple write port and take effect glitch-free at the channel's next toggle.
- Sits between the board oscillator domain and LED-scanning/animation logic that needs several unrelated rates.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- DIV_WIDTH, 24, width of half-period divisor and channel counter.
- DEFAULT_DIV, 24'd6_750_000, half-period loaded into every channel at reset (must fit DIV_WIDTH).
- CH_IDX_WIDTH, 2, width of wr_ch; must satisfy 2**CH_IDX_WIDTH >= CHANNELS.

Ports:
- clk  input  1  system clock; all logic on posedge.
- sys_rst_n  input  1  asynchronous active-low reset.
- en  input  CHANNELS  per-channel run enable.
- wr_en  input  1  divisor write strobe, one cycle.
- wr_ch  input  CH_IDX_WIDTH  target channel of write.
- wr_data  input  DIV_WIDTH  new half-period value.
- slow_clk  output  CHANNELS  per-channel divided clock (registered).
- tick  output  CHANNELS  per-channel one-cycle pulse, registered.
- pending  output  CHANNELS  shadow divisor written but not yet active.

Behaviour:
- Reset (sys_rst_n low, asynchronous):
  - per channel: cnt=0, slow_clk=0, tick=0, pending=0;
  - active_div and shadow_div both = DEFAULT_DIV.
- Per channel, active divisor D >= 1 and en=1:
  - each clk: if cnt == D-1, then cnt<=0 and slow_clk<=~slow_clk ("wrap"); else cnt<=cnt+1.
  - slow_clk period = 2*D clk cycles, exact 50% duty.
  - first rising edge of slow_clk appears D cycles after reset release.
- tick:
  - asserted for exactly the one cycle in which slow_clk has just become 1, i.e. registered together with the 0->1 toggle;
  - low in all other cycles.
- en=0: cnt and slow_clk hold their values; tick=0; pending writes stay pending.
- D == 0 (channel off): cnt forced 0, slow_clk forced 0, tick 0, regardless of en.
- Write (wr_en=1, wr_ch < CHANNELS):
  - shadow_div[wr_ch]<=wr_data; pending[wr_ch]<=1.
  - wr_ch >= CHANNELS: write ignored, no state change.
- Shadow transfer: active_div<=shadow_div and pending<=0 when any of the following holds:
  - (a) the channel wraps;
  - (b) active_div == 0, in which case the transfer happens the cycle after the write;
  - (c) the channel has en=0 and cnt == 0.
- Write in the same cycle as that channel's wrap: wr_data goes directly into both active_div and shadow_div; pending stays 0. The write wins over the older shadow.
- Shrinking the divisor never truncates a half-period. The change applies only at a wrap, so no runt pulses.
- Counter arithmetic: unsigned, DIV_WIDTH bits. D = 2**DIV_WIDTH-1 is legal, and cnt never overflows.
- Channels are fully independent except for the shared write port.
- Reset mid-operation: all state returns to reset values immediately; no partial write survives.

Optional Feature:
- Macro: CLOCK_DIVIDER_BANK_SYNC_EN
- Defined:
  - adds input port phase_sync (1 bit, after wr_data).
  - phase_sync=1 for one cycle: every channel sets cnt<=0, slow_clk<=0, tick<=0.
  - any pending shadow becomes active and pending clears, so all channels restart phase-aligned.
  - phase_sync takes priority over wrap and write-transfer in that cycle; a simultaneous wr_en still updates shadow_div and sets pending.
- Not defined: port absent; no alignment mechanism.

Test Plan:
- Reset release, DEFAULT_DIV overridden to 3, en=all 1 -> slow_clk[0] rises at cycle 3, falls at 6, period 6; tick[0] high only at cycles 3, 9, 15.
- Channel 1 at D=5, write wr_data=2 at cnt=1 -> pending[1]=1 until the wrap at cnt=4; then period becomes 4, and no half-period shorter than 5 precedes the change.
- Write 0 to channel 2 -> after next wrap slow_clk[2]=0 and tick[2]=0 permanently; then write 4 -> active the following cycle, first rise 4 cycles later.
- en[0] dropped for 10 cycles mid half-period -> slow_clk[0] and cnt frozen, tick[0]=0; resumes with the remaining count, and the total half-period equals D+10.
- wr_ch=3 with CHANNELS=3 -> no change to any shadow, active or pending; a write coinciding with a wrap -> new D used immediately, pending=0.
- (SYNC_EN) channels at D=3,5,7 free-running, pulse phase_sync -> all slow_clk=0 next cycle, ticks at cycles 3, 5 and 7 after sync; async reset asserted mid-count -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock divider with shadowed, glitch-free divisor updates.
// Optional macro CLOCK_DIVIDER_BANK_SYNC_EN adds a phase_sync input that realigns every channel.
module clock_divider_bank #(
  parameter int unsigned          CHANNELS     = 4,
  parameter int unsigned          DIV_WIDTH    = 24,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV  = DIV_WIDTH'(6_750_000),
  parameter int unsigned          CH_IDX_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    sys_rst_n,
  input  logic [CHANNELS-1:0]     en,
  input  logic                    wr_en,
  input  logic [CH_IDX_WIDTH-1:0] wr_ch,
  input  logic [DIV_WIDTH-1:0]    wr_data,
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
  input  logic                    phase_sync,
`endif
  output logic [CHANNELS-1:0]     slow_clk,
  output logic [CHANNELS-1:0]     tick,
  output logic [CHANNELS-1:0]     pending
);

  typedef logic [DIV_WIDTH-1:0] div_word_t;

  div_word_t cnt_q    [CHANNELS];
  div_word_t cnt_d    [CHANNELS];
  div_word_t active_q [CHANNELS];
  div_word_t active_d [CHANNELS];
  div_word_t shadow_q [CHANNELS];
  div_word_t shadow_d [CHANNELS];

  logic [CHANNELS-1:0] slow_q,    slow_d;
  logic [CHANNELS-1:0] tick_q,    tick_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] wrap;
  logic                sync_pulse;

`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
  assign sync_pulse = phase_sync;
`else
  assign sync_pulse = 1'b0;
`endif

  // Out-of-range wr_ch never matches any channel index, so such writes vanish.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_en && (wr_ch == CH_IDX_WIDTH'(i));
      wrap[i]   = (active_q[i] != '0) && en[i] &&
                  (cnt_q[i] == active_q[i] - DIV_WIDTH'(1));
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: every comb output gets a hold/default value first so no path infers a latch.
      cnt_d[i]     = cnt_q[i];
      slow_d[i]    = slow_q[i];
      tick_d[i]    = 1'b0;
      active_d[i]  = active_q[i];
      shadow_d[i]  = shadow_q[i];
      pending_d[i] = pending_q[i];

      if (sync_pulse) begin
        cnt_d[i]     = '0;
        slow_d[i]    = 1'b0;
        active_d[i]  = shadow_q[i];
        pending_d[i] = 1'b0;
      end else if (active_q[i] == '0) begin
        cnt_d[i]     = '0;
        slow_d[i]    = 1'b0;
        active_d[i]  = shadow_q[i];
        pending_d[i] = 1'b0;
      end else if (wrap[i]) begin
        cnt_d[i]     = '0;
        slow_d[i]    = ~slow_q[i];
        tick_d[i]    = ~slow_q[i];
        active_d[i]  = shadow_q[i];
        pending_d[i] = 1'b0;
      end else if (en[i]) begin
        cnt_d[i]     = cnt_q[i] + DIV_WIDTH'(1);
      end else if (cnt_q[i] == '0) begin
        active_d[i]  = shadow_q[i];
        pending_d[i] = 1'b0;
      end

      // A write landing on the wrap bypasses the shadow so the newest value wins.
      if (wr_hit[i]) begin
        shadow_d[i]  = wr_data;
        pending_d[i] = 1'b1;
        if (wrap[i] && !sync_pulse) begin
          active_d[i]  = wr_data;
          pending_d[i] = 1'b0;
        end
      end
    end
  end

  // NOTE: the divisor arrays are reset too, because every channel must restart at DEFAULT_DIV.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]    <= '0;
        active_q[i] <= DEFAULT_DIV;
        shadow_q[i] <= DEFAULT_DIV;
      end
      slow_q    <= '0;
      tick_q    <= '0;
      pending_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]    <= cnt_d[i];
        active_q[i] <= active_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      slow_q    <= slow_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
    end
  end

  assign slow_clk = slow_q;
  assign tick     = tick_q;
  assign pending  = pending_q;

endmodule
